rr_mux_reg: RTL
===============

// Module: rr_mux_reg
// PURPOSE
//  Registered N-channel, W-bit selector that generalises the fixed 2:1 mux to
//  CHANNELS inputs. Selection is made by an internal arbiter: round-robin or
//  fixed-priority. Each input and the output use a valid/ready handshake.
//  The block merges operand/result streams onto one bus feeding the multiplier datapath.
// PARAMETERS
//  WIDTH     8  data bits per channel (>=1)
//  CHANNELS  4  number of input channels (>=2); SEL_W = clog2(CHANNELS) localparam
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               asynchronous, active-high reset
//  mode       in   1               1 = round-robin, 0 = fixed priority (ch0 highest)
//  in_data    in   CHANNELS*WIDTH  channel i on bits [i*WIDTH +: WIDTH]
//  in_valid   in   CHANNELS        per-channel data valid
//  in_ready   out  CHANNELS        per-channel accept (one-hot or zero)
//  out_data   out  WIDTH           registered selected data
//  out_sel    out  SEL_W           index of channel that supplied out_data
//  out_valid  out  1               out_data/out_sel valid
//  out_ready  in   1               downstream accepts out_data
// BEHAVIOUR
//  Reset (async, rst=1):
//   - out_valid=0, out_data=0, out_sel=0, rr_ptr=CHANNELS-1 (ch0 wins first).
//   - in_ready=0 while rst=1.
//  load = !out_valid | out_ready (output register empty or draining this cycle).
//  Arbitration (combinational, same cycle):
//   - RR: first valid channel scanning rr_ptr+1, rr_ptr+2 ... mod CHANNELS.
//     Wrap from CHANNELS-1 to 0.
//   - Fixed: lowest-index valid channel.
//   - in_ready[grant]=load; all other in_ready=0. No valid input -> in_ready=0.
//   - in_ready may depend combinationally on in_valid and out_ready.
//  Clock edge:
//   - Transfer on channel g (in_valid[g] & in_ready[g]):
//     out_data<=in_data[g], out_sel<=g, out_valid<=1, rr_ptr<=g (both modes).
//   - load with no valid input: out_valid<=0; out_data/out_sel hold.
//   - !load (out_valid & !out_ready): all registers hold; no input accepted.
//  Latency: 1 cycle, input transfer -> out_valid.
//  Throughput: one transfer per cycle when out_ready=1.
//  Simultaneous drain and fill in the same cycle is allowed (no bubble).
//  Mode change takes effect at the next arbitration; rr_ptr is preserved.
//  Sources hold in_valid/in_data until in_ready. The block does not check this.
//  A channel deasserting in_valid before grant is skipped, not an error.
//  Reset mid-operation discards held data immediately; no partial transfer.
//  CHANNELS not a power of 2: indices >= CHANNELS are never granted.
// TESTING
//  1 rst=1 with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0.
//  2 rst released, mode=1, only ch2 valid data 8'hA5, out_ready=1
//    -> in_ready=4'b0100; next cycle out_data=A5, out_sel=2, out_valid=1.
//  3 mode=1, all 4 valid continuously, out_ready=1
//    -> out_sel sequence 0,1,2,3,0,1 over consecutive cycles.
//  4 mode=0, all valid -> out_sel=0 every cycle; ch1..3 in_ready stay 0.
//    Drop ch0 -> out_sel=1.
//  5 out_valid=1, out_ready=0 for 3 cycles -> out_data/out_sel stable, in_ready=0.
//    out_ready=1 -> next grant transfers in the same cycle.
//  6 rst pulsed while out_valid=1 and ch1 pending -> out_valid=0 at once.
//    After release, first grant is ch0 if valid.

Source files
------------

// File: rtl/rr_mux_reg.sv
// Registered CHANNELS:1 selector with round-robin or fixed-priority arbitration
// and valid/ready handshakes on every input and on the output.
module rr_mux_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic signed [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0]        sel_p1;
  logic                    vld_p1;
  logic [SEL_W-1:0]        rr_ptr;
  logic [SEL_W-1:0]        grant;
  logic                    found;
  logic                    load;
  logic                    xfer;

  assign load = !vld_p1 || out_ready;
  assign xfer = found && load;

  // Stage p0: combinational arbitration over the current valid inputs.
  always_comb begin
    int idx;
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    cand  = '0;
    if (mode) begin
      // Scan starts one past the last winner so it becomes lowest priority.
      for (int k = 1; k <= CHANNELS; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        cand = SEL_W'(idx);
        if (!found && in_valid[cand]) begin
          found = 1'b1;
          grant = cand;
        end
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!found && in_valid[i]) begin
          found = 1'b1;
          grant = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer && !rst) in_ready[grant] = 1'b1;
  end

  // Stage p1: output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p1 <= '0;
      sel_p1  <= '0;
      vld_p1  <= 1'b0;
      rr_ptr  <= SEL_W'(CHANNELS - 1);
    end else if (xfer) begin
      data_p1 <= in_data[int'(grant)*WIDTH +: WIDTH];
      sel_p1  <= grant;
      vld_p1  <= 1'b1;
      rr_ptr  <= grant;
    end else if (load) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_data  = data_p1;
  assign out_sel   = sel_p1;
  assign out_valid = vld_p1;

endmodule
